// File: rtl/ws2812_driver.sv
// WS2812 single-wire serialiser: captures one GRB colour on a valid/ready handshake,
// sends it to NUM_LEDS chained LEDs, then holds the line low for the latch period.
module ws2812_driver #(
  parameter int unsigned NUM_LEDS     = 1,
  parameter int unsigned BIT_CYCLES   = 12,
  parameter int unsigned T0H_CYCLES   = 4,
  parameter int unsigned T1H_CYCLES   = 8,
  parameter int unsigned LATCH_CYCLES = 600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int unsigned CYC_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned LED_W   = 8;

  if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))) begin : g_bad_timing
    $error("ws2812_driver: bit timing requires T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dout_q, dout_d;

  logic [CYC_W-1:0]    cyc_inc;
  logic [CYC_W-1:0]    high_len;

  assign cyc_inc  = cyc_q + CYC_W'(1);
  assign high_len = shift_q[WORD_W-1] ? CYC_W'(T1H_CYCLES) : CYC_W'(T0H_CYCLES);

  // cyc_q is the index of the current cycle within a bit (or within the latch period)
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    shift_d = shift_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    led_d   = led_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          word_d  = {green, red, blue};
          shift_d = {green, red, blue};
          cyc_d   = '0;
          bit_d   = '0;
          led_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          dout_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      S_HIGH: begin
        cyc_d = cyc_inc;
        if (cyc_inc == high_len) begin
          dout_d  = 1'b0;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        cyc_d = cyc_inc;
        if (cyc_inc == CYC_W'(BIT_CYCLES)) begin
          cyc_d = '0;
          if (bit_q < BIT_W'(WORD_W - 1)) begin
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            bit_d   = bit_q + BIT_W'(1);
            dout_d  = 1'b1;
            state_d = S_HIGH;
          end else if (led_q < LED_W'(NUM_LEDS - 1)) begin
            shift_d = word_q;
            bit_d   = '0;
            led_d   = led_q + LED_W'(1);
            dout_d  = 1'b1;
            state_d = S_HIGH;
          end else begin
            state_d = S_LATCH;
          end
        end
      end

      S_LATCH: begin
        cyc_d = cyc_inc;
        if (cyc_inc == CYC_W'(LATCH_CYCLES)) begin
          cyc_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      shift_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Directed bench for ws2812_driver: one single-LED and one three-LED instance,
// bit waveforms decoded from dout and compared against hand-computed GRB words.
module tb_ws2812_driver;

  localparam int unsigned BITC  = 12;
  localparam int unsigned LATCH = 600;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] red, green, blue;
  logic       valid1, valid3;
  logic       ready1, busy1, done1, dout1;
  logic       ready3, busy3, done3, dout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ws2812_driver #(.NUM_LEDS(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .valid   (valid1),
    .ready   (ready1),
    .busy    (busy1),
    .done    (done1),
    .dout    (dout1)
  );

  ws2812_driver #(.NUM_LEDS(3)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .valid   (valid3),
    .ready   (ready3),
    .busy    (busy3),
    .done    (done3),
    .dout    (dout3)
  );

  // {ready, busy, done, dout} of the selected instance
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {ready3, busy3, done3, dout3} : {ready1, busy1, done1, dout1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hs(input bit sel, input logic [23:0] grb, input bit hold);
    logic [3:0] o;
    @(negedge clk);
    {green, red, blue} = grb;
    if (sel) valid3 = 1'b1; else valid1 = 1'b1;
    o = outs(sel);
    check("hs_ready", o[3], 1'b1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) valid3 = 1'b0; else valid1 = 1'b0;
    end
    o = outs(sel);
    check("hs_start", o, 4'b0101);
  endtask

  // Samples every cycle from the first data cycle through the done cycle
  task automatic measure(input bit sel, input int n, input logic [23:0] exp_word);
    logic [3:0]  o;
    logic [23:0] dec;
    int          wave_err;
    int          latch_err;
    int          h;
    int          exp_h;
    wave_err  = 0;
    latch_err = 0;
    for (int led = 0; led < n; led++) begin
      dec = '0;
      for (int b = 0; b < 24; b++) begin
        h     = 0;
        exp_h = exp_word[23 - b] ? 8 : 4;
        for (int c = 0; c < int'(BITC); c++) begin
          @(negedge clk);
          o = outs(sel);
          if (o[0] !== (c < exp_h)) wave_err++;
          if (o[3:1] !== 3'b010) wave_err++;
          if (o[0] === 1'b1) h++;
        end
        dec = {dec[22:0], (h >= 6)};
      end
      check($sformatf("word_led%0d", led), dec, exp_word);
    end
    check("bit_waveform", wave_err, 0);
    for (int c = 0; c < int'(LATCH); c++) begin
      @(negedge clk);
      o = outs(sel);
      if (o !== 4'b0100) latch_err++;
    end
    check("latch_low", latch_err, 0);
    @(negedge clk);
    o = outs(sel);
    check("done_pulse", o, 4'b1010);
  endtask

  task automatic done_clear(input bit sel);
    logic [3:0] o;
    @(negedge clk);
    o = outs(sel);
    check("done_clear", o, 4'b1000);
  endtask

  initial begin
    logic [3:0] o;
    reset_n = 1'b0;
    valid1  = 1'b1;
    valid3  = 1'b1;
    red     = 8'($urandom);
    green   = 8'($urandom);
    blue    = 8'($urandom);

    // 1: reset held with valid asserted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      check("reset_dut1", outs(1'b0), 4'b1000);
      check("reset_dut3", outs(1'b1), 4'b1000);
    end
    valid1  = 1'b0;
    valid3  = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_dut1", outs(1'b0), 4'b1000);

    // 2: single LED, GRB A5_00_FF
    hs(1'b0, 24'hA500FF, 1'b0);
    measure(1'b0, 1, 24'hA500FF);
    done_clear(1'b0);

    // 3: three LEDs, colour inputs scrambled mid-frame
    hs(1'b1, 24'h123456, 1'b0);
    {green, red, blue} = 24'hDEAD00;
    measure(1'b1, 3, 24'h123456);
    done_clear(1'b1);

    // 4: valid held high; second colour presented mid-frame
    hs(1'b0, 24'h0F81C3, 1'b1);
    {green, red, blue} = 24'h3C5AA5;
    measure(1'b0, 1, 24'h0F81C3);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    o = outs(1'b0);
    check("b2b_rise", o, 4'b0101);
    measure(1'b0, 1, 24'h3C5AA5);
    done_clear(1'b0);

    // 5: asynchronous reset during bit 10
    hs(1'b0, 24'h123456, 1'b0);
    repeat (int'(BITC) * 10 + 1) @(negedge clk);
    check("pre_reset_high", dout1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(1'b0), 4'b1000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs(1'b0), 4'b1000);
    hs(1'b0, 24'h123456, 1'b0);
    measure(1'b0, 1, 24'h123456);
    done_clear(1'b0);

    // 6: all zeros then all ones
    hs(1'b0, 24'h000000, 1'b0);
    measure(1'b0, 1, 24'h000000);
    done_clear(1'b0);
    hs(1'b0, 24'hFFFFFF, 1'b0);
    measure(1'b0, 1, 24'hFFFFFF);
    done_clear(1'b0);

    repeat (3) @(negedge clk);
    check("final_idle", outs(1'b0), 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
